// File: rtl/lf_edge_pkg.sv
// Shared constants for the edge period capture block: default sizes and
// the layout of the {level, period} word pushed into the capture FIFO.
package lf_edge_pkg;

    localparam int CNT_W_DEF      = 15;
    localparam int DEPTH_DEF      = 4;
    localparam int WORD_W_DEF     = CNT_W_DEF + 1;
    localparam int LEVEL_BIT_DEF  = CNT_W_DEF;
    localparam int PERIOD_MSB_DEF = CNT_W_DEF - 1;
    localparam int PERIOD_LSB     = 0;

    // Word width for a given counter width: one level bit above the period.
    function automatic int word_w(input int cnt_w);
        return cnt_w + 1;
    endfunction

    // Bit index of the level flag for a given counter width.
    function automatic int level_bit(input int cnt_w);
        return cnt_w;
    endfunction

endpackage

// File: rtl/lf_edge_fifo.sv
// Small synchronous FIFO holding captured {level, period} words.
// Pointers wrap naturally because DEPTH is a power of two. A push into a
// full FIFO is accepted only when the head is popped in the same cycle;
// otherwise it is reported on o_drop and the contents stay untouched.
module lf_edge_fifo
    import lf_edge_pkg::*;
#(
    parameter int WIDTH = WORD_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic                     o_valid,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_fill,
    output logic                     o_drop
);

    localparam int               AW        = $clog2(DEPTH);
    localparam logic [AW-1:0]    PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]      FILL_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]      FILL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_fill;

    logic w_pop;
    logic w_full;
    logic w_wr;

    // Pop and accepted-write qualification from current occupancy.
    always_comb begin
        w_pop  = i_pop && (r_fill != {(AW+1){1'b0}});
        w_full = (r_fill == FILL_FULL);
        w_wr   = i_push && (!w_full || w_pop);
    end

    // Storage write; contents need no reset since valid gates the output.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy update, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_fill   <= {(AW+1){1'b0}};
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_wr, w_pop})
                2'b10:   r_fill <= r_fill + FILL_ONE;
                2'b01:   r_fill <= r_fill - FILL_ONE;
                default: r_fill <= r_fill;
            endcase
        end
    end

    assign o_valid = (r_fill != {(AW+1){1'b0}});
    assign o_data  = r_mem[r_rd_ptr];
    assign o_fill  = r_fill;
    assign o_drop  = i_push && w_full && !w_pop;

endmodule

// File: rtl/lf_edge_period_capture.sv
// Measures the number of clk cycles between consecutive edges reported by an
// upstream edge detector (via a toggle) and queues {level, period} words.
// The first edge after reset or after enable rises only arms the counter.
module lf_edge_period_capture
    import lf_edge_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     edge_toggle,
    input  logic                     edge_state,
    input  logic                     clear_ovf,
    output logic                     out_valid,
    output logic [CNT_W:0]           out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     overflow
);

    localparam int               WORD_W  = word_w(CNT_W);
    localparam int               LVL_BIT = level_bit(CNT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic               r_toggle_q;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_armed;
    logic               r_overflow;

    logic               w_event;
    logic               w_push;
    logic               w_drop;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [WORD_W-1:0]  w_word;

    // Event detection, push qualification and next counter value.
    always_comb begin
        w_event = enable && (edge_toggle != r_toggle_q);
        w_push  = w_event && r_armed;
        w_word  = {WORD_W{1'b0}};
        w_word[LVL_BIT]     = edge_state;
        w_word[CNT_W-1:0]   = r_cnt;
        if (!enable) begin
            w_cnt_next = {CNT_W{1'b0}};
        end else if (w_event) begin
            w_cnt_next = CNT_ONE;
        end else if (r_cnt != CNT_MAX) begin
            w_cnt_next = r_cnt + CNT_ONE;
        end else begin
            w_cnt_next = r_cnt;
        end
    end

    // Toggle history; loaded from the input in reset so release is quiet.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_toggle_q <= edge_toggle;
        end else begin
            r_toggle_q <= edge_toggle;
        end
    end

    // Period counter and arming flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= {CNT_W{1'b0}};
            r_armed <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            if (!enable) begin
                r_armed <= 1'b0;
            end else if (w_event) begin
                r_armed <= 1'b1;
            end
        end
    end

    // Sticky overflow; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clear_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    lf_edge_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_word),
        .i_pop   (out_ready),
        .o_valid (out_valid),
        .o_data  (out_data),
        .o_fill  (fill),
        .o_drop  (w_drop)
    );

    assign overflow = r_overflow;

endmodule

// File: tb/tb_lf_edge_period_capture.sv
// Directed bench for lf_edge_period_capture. A default instance (CNT_W=15)
// and a narrow instance (CNT_W=4) share the same stimulus; the narrow one
// shows counter saturation. A randomized back-pressure run ends the sequence.
module tb_lf_edge_period_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, enable, edge_toggle, edge_state, clear_ovf, out_ready;
    logic        out_valid, overflow;
    logic [15:0] out_data;
    logic [2:0]  fill;
    logic        s_valid, s_ovf;
    logic [4:0]  s_data;
    logic [2:0]  s_fill;

    int checks   = 0;
    int failures = 0;
    int drops    = 0;

    logic [15:0] m_q [$];
    logic [4:0]  s_q [$];
    logic [15:0] mq  [$];

    lf_edge_period_capture dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .edge_toggle(edge_toggle),
        .edge_state(edge_state), .clear_ovf(clear_ovf), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .fill(fill), .overflow(overflow)
    );

    lf_edge_period_capture #(.CNT_W(4), .DEPTH(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .enable(enable), .edge_toggle(edge_toggle),
        .edge_state(edge_state), .clear_ovf(clear_ovf), .out_valid(s_valid),
        .out_data(s_data), .out_ready(out_ready), .fill(s_fill), .overflow(s_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: record words popped at the coming edge, then advance.
    task automatic tick();
        if (out_valid === 1'b1 && out_ready) m_q.push_back(out_data);
        if (s_valid === 1'b1 && out_ready) s_q.push_back(s_data);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic fire(input logic lvl);
        edge_toggle = ~edge_toggle;
        edge_state  = lvl;
        tick();
    endtask

    // One cycle of the randomized run, checked against a queue model.
    task automatic rtick(input bit ev, input logic lvl, input int per,
                         input bit arm, input bit rnd);
        bit          exp_v, pop, full;
        logic [15:0] w;
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (ev) begin
            edge_toggle = ~edge_toggle;
            edge_state  = lvl;
        end
        exp_v = (mq.size() != 0);
        full  = (mq.size() == 4);
        chk("bp_valid", {31'd0, out_valid}, {31'd0, exp_v});
        pop = exp_v && out_ready;
        if (pop) begin
            chk("bp_data", {16'd0, out_data}, {16'd0, mq[0]});
            void'(mq.pop_front());
        end
        if (ev && !arm) begin
            w = {lvl, 15'(per)};
            if (!full || pop) mq.push_back(w);
            else drops++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int gap;
        logic lvl;

        rst_n = 1'b0; enable = 1'b0; edge_toggle = 1'b0; edge_state = 1'b0;
        clear_ovf = 1'b0; out_ready = 1'b0;
        idle(3);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_fill", {29'd0, fill}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_s_fill", {29'd0, s_fill}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Arming: toggles at cycles 10, 30, 75 -> periods 20 and 45.
        out_ready = 1'b1;
        enable = 1'b1;
        idle(10); fire(1'b1);
        idle(19); fire(1'b0);
        idle(44); fire(1'b1);
        idle(5);
        chk("arm_count", m_q.size(), 32'd2);
        chk("arm_w0", {16'd0, m_q[0]}, 32'h0014);
        chk("arm_w1", {16'd0, m_q[1]}, 32'h802D);
        chk("arm_s_w0", {27'd0, s_q[0]}, 32'h0F);
        chk("arm_s_w1", {27'd0, s_q[1]}, 32'h1F);
        m_q.delete(); s_q.delete();

        // Saturation: events 40 cycles apart; narrow counter stops at 15.
        enable = 1'b0; tick(); enable = 1'b1;
        fire(1'b0); idle(39); fire(1'b0); idle(39); fire(1'b1); idle(3);
        chk("sat_count", s_q.size(), 32'd2);
        chk("sat_s_w0", {27'd0, s_q[0]}, 32'h0F);
        chk("sat_s_w1", {27'd0, s_q[1]}, 32'h1F);
        chk("sat_m_w0", {16'd0, m_q[0]}, 32'h0028);
        chk("sat_m_w1", {16'd0, m_q[1]}, 32'h8028);
        m_q.delete(); s_q.delete();

        // Overflow: arm plus six events of period 5 with no consumer.
        out_ready = 1'b0;
        enable = 1'b0; tick(); enable = 1'b1;
        fire(1'b0);
        for (int k = 1; k <= 6; k++) begin
            idle(4);
            fire(1'(k % 2));
        end
        chk("ovf_fill", {29'd0, fill}, 32'd4);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_head", {16'd0, out_data}, 32'h8005);
        chk("ovf_s_fill", {29'd0, s_fill}, 32'd4);
        chk("ovf_s_flag", {31'd0, s_ovf}, 32'd1);
        chk("ovf_s_head", {27'd0, s_data}, 32'h15);
        clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
        chk("ovf_clear", {31'd0, overflow}, 32'd0);

        // Full plus pop: event and pop together keep fill at 4.
        idle(7);
        out_ready = 1'b1; fire(1'b1); out_ready = 1'b0;
        chk("fp_fill", {29'd0, fill}, 32'd4);
        chk("fp_ovf", {31'd0, overflow}, 32'd0);
        chk("fp_head", {16'd0, out_data}, 32'h0005);
        out_ready = 1'b1; idle(5);
        chk("fp_count", m_q.size(), 32'd5);
        chk("fp_first", {16'd0, m_q[0]}, 32'h8005);
        chk("fp_last", {16'd0, m_q[4]}, 32'h8009);
        chk("fp_empty", {29'd0, fill}, 32'd0);

        // Reset mid-stream with three words queued.
        out_ready = 1'b0;
        enable = 1'b0; tick(); enable = 1'b1;
        fire(1'b0);
        for (int k = 0; k < 3; k++) begin
            idle(4);
            fire(1'b1);
        end
        chk("rs_fill3", {29'd0, fill}, 32'd3);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("rs_fill0", {29'd0, fill}, 32'd0);
        chk("rs_valid", {31'd0, out_valid}, 32'd0);
        idle(4); fire(1'b0);
        chk("rs_arm_only", {29'd0, fill}, 32'd0);
        idle(4); fire(1'b1);
        chk("rs_next_fill", {29'd0, fill}, 32'd1);
        chk("rs_next_word", {16'd0, out_data}, 32'h8005);

        // Random back-pressure over 1000 events spaced 5..8 cycles.
        out_ready = 1'b1; idle(2);
        enable = 1'b0; tick(); enable = 1'b1;
        mq.delete(); drops = 0;
        rtick(1'b1, 1'b0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            gap = int'($urandom_range(5, 8));
            lvl = 1'($urandom_range(0, 1));
            for (int j = 0; j < gap - 1; j++) rtick(1'b0, 1'b0, 0, 1'b0, 1'b1);
            rtick(1'b1, lvl, gap, 1'b0, 1'b1);
        end
        for (int j = 0; j < 8; j++) rtick(1'b0, 1'b0, 0, 1'b0, 1'b0);
        chk("bp_model_empty", mq.size(), 32'd0);
        chk("bp_fill", {29'd0, fill}, 32'd0);
        chk("bp_ovf", {31'd0, overflow}, {31'd0, (drops != 0)});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lf_edge_period_capture.md
LF_EDGE_PERIOD_CAPTURE -- requirements
Module: lf_edge_period_capture

Interface
REQ-001 Parameter CNT_W, default 15, width of the period counter in clk cycles.
REQ-002 Parameter DEPTH, default 4, number of FIFO entries (power of two, at least 2).
REQ-003 The block SHALL have one clock and a synchronous, active-low reset; ports follow.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 enable  input  1  capture enable.
REQ-007 edge_toggle  input  1  toggles once per detected edge (from edge detector).
REQ-008 edge_state  input  1  level after the most recent edge (1 = high, 0 = low).
REQ-009 clear_ovf  input  1  single-cycle pulse that clears the overflow flag.
REQ-010 out_valid  output  1  FIFO head word is available.
REQ-011 out_data  output  CNT_W+1  head word {level, period}: MSB is the level, LSBs are the period.
REQ-012 out_ready  input  1  consumer accepts the head word.
REQ-013 fill  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-014 overflow  output  1  sticky flag: a word was dropped because the FIFO was full.

Function
REQ-015 toggle_q SHALL register edge_toggle every cycle; an event occurs in any cycle where enable=1 and edge_toggle differs from toggle_q.
REQ-016 Period counter: set to 1 on an event cycle; otherwise increment by 1, saturating at 2^CNT_W-1 with no wrap.
REQ-017 Word on an event: {edge_state, counter value before the update}, so the period is the exact number of cycles between consecutive events, or saturated.
REQ-018 Arming: the first event after reset or after an enable rise SHALL only set armed=1 and restart the counter; it SHALL NOT push a word.
REQ-019 While enable=0: counter held at 0, armed cleared, no pushes; the FIFO still drains normally.
REQ-020 Push latency: an event at cycle t SHALL make the word visible on out_data/out_valid after the clock edge ending cycle t (one-cycle latency).
REQ-021 Pop: occurs when out_valid=1 and out_ready=1; out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 Empty: out_valid=0 and fill=0; out_ready is ignored.
REQ-023 Full, event with no pop: the word is dropped, FIFO contents are unchanged, and overflow is set at the next edge.
REQ-024 Full, event with a pop in the same cycle: push accepted, fill stays at DEPTH.
REQ-025 Push and pop together when not full or empty: fill unchanged.
REQ-026 clear_ovf together with a new drop in the same cycle: overflow SHALL remain 1 (set wins).
REQ-027 Read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-028 While rst_n=0 at a clock edge: FIFO empty, fill=0, out_valid=0, overflow=0, counter=0, armed=0, toggle_q loaded from edge_toggle (no spurious event on release).
REQ-029 Reset mid-operation SHALL discard all queued words; out_data is don't-care while out_valid=0.

Structure
REQ-030 Shared package lf_edge_pkg SHALL hold the CNT_W and DEPTH defaults, the word width, the level-bit index and the period field range.
REQ-031 FIFO storage, pointers and fill SHALL be implemented in one sub-module, lf_edge_fifo; event, counter and arming logic stay in the top module.

Verification
REQ-032 Arming: enable=1, toggle at cycles 10, 30, 75, out_ready=1 -> exactly two words, periods 20 and 45, each with its edge_state level.
REQ-033 Saturation: CNT_W=4, events 40 cycles apart -> period 15, no wrap.
REQ-034 Overflow: out_ready=0, 6 armed events, DEPTH=4 -> fill=4, overflow=1, head word is the first event's; clear_ovf pulse -> overflow=0.
REQ-035 Full plus pop: fill=4, event and pop in the same cycle -> fill stays 4, overflow stays 0, new word is last in order.
REQ-036 Back-pressure: out_ready toggled randomly over 1000 events at spacing >=5 cycles with DEPTH=4 -> output words match the reference model in order, none lost.
REQ-037 Reset mid-stream: rst_n=0 for 1 cycle with fill=3 -> next cycle fill=0, out_valid=0; the next event only arms.
